// File: rtl/fll_cfg_master.sv
// fll_cfg_master: turns single-word command requests into req/ack
// transactions on an FLL configuration slave port, returns read data or a
// timeout error on a one-cycle response strobe, and monitors FLL lock.
module fll_cfg_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_wrn_i,
    input  logic [1:0]  cmd_add_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i,
    output logic        lock_o,
    output logic        lock_lost_o,
    input  logic        lock_lost_clr_i
);

    // A zero timeout still needs a one-bit counter so the vectors stay legal.
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LAST_I);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP,
        ST_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic              tmo_hit;
    logic              cmd_accept;
    logic              cnt_clr;
    logic              rsp_load;
    logic [31:0]       rsp_rdata_d;
    logic              rsp_err_d;
    logic              lock_sync_q;
    logic              lock_prev_q;

    // An ack left high by a timed-out transaction must drop before the next command.
    assign cmd_ready_o = (state_q == ST_IDLE) && !fll_ack_i && !rst_i;
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;
    assign fll_req_o   = (state_q == ST_REQ);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and response selection; an ack in the timeout cycle wins.
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        rsp_load    = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_REQ;
                    cnt_clr = 1'b1;
                end
            end
            ST_REQ: begin
                if (fll_ack_i) begin
                    rsp_load    = 1'b1;
                    rsp_rdata_d = fll_wrn_o ? fll_r_data_i : '0;
                    cnt_clr     = 1'b1;
                    state_d     = ST_DROP;
                end else if (tmo_hit) begin
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_DROP: begin
                if (!fll_ack_i) begin
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating timeout counter, restarted on entry to REQ and DROP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (cnt_clr) begin
            tmo_cnt_q <= '0;
        end else if (((state_q == ST_REQ) || (state_q == ST_DROP)) && (tmo_cnt_q != '1)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Command fields are latched on accept and held until the next accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fll_wrn_o  <= 1'b0;
            fll_add_o  <= '0;
            fll_data_o <= '0;
        end else if (cmd_accept) begin
            fll_wrn_o  <= cmd_wrn_i;
            fll_add_o  <= cmd_add_i;
            fll_data_o <= cmd_data_i;
        end
    end

    // Response data/error registers, held until the next transaction updates them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (rsp_load) begin
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

    // Two-flop lock synchroniser plus a delayed copy to spot 1->0 edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync_q <= 1'b0;
            lock_o      <= 1'b0;
            lock_prev_q <= 1'b0;
        end else begin
            lock_sync_q <= fll_lock_i;
            lock_o      <= lock_sync_q;
            lock_prev_q <= lock_o;
        end
    end

    // Sticky lock-loss flag; a new loss outranks a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_lost_o <= 1'b0;
        end else if (lock_prev_q && !lock_o) begin
            lock_lost_o <= 1'b1;
        end else if (lock_lost_clr_i) begin
            lock_lost_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fll_cfg_master.sv
// Self-checking bench for fll_cfg_master: randomized commands against a
// transaction-level expectation, a reactive FLL slave, and a lock model.
module tb_fll_cfg_master;

    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_wrn_i = 1'b0;
    logic [1:0]  cmd_add_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        fll_req_o;
    logic        fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack_i = 1'b0;
    logic [31:0] fll_r_data_i = '0;
    logic        fll_lock_i = 1'b0;
    logic        lock_o;
    logic        lock_lost_o;
    logic        lock_lost_clr_i = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          ack_dly = NEVER;
    bit          ack_force = 1'b0;
    int          hi_cnt = 0;
    int          req_len = 0;
    bit          mon_en = 1'b1;
    logic        req_prev = 1'b0;
    logic [34:0] exp_fields = '0;
    logic        lin_h [0:8191];
    logic        exp_lost = 1'b0;

    fll_cfg_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_wrn_i       (cmd_wrn_i),
        .cmd_add_i       (cmd_add_i),
        .cmd_data_i      (cmd_data_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .fll_req_o       (fll_req_o),
        .fll_wrn_o       (fll_wrn_o),
        .fll_add_o       (fll_add_o),
        .fll_data_o      (fll_data_o),
        .fll_ack_i       (fll_ack_i),
        .fll_r_data_i    (fll_r_data_i),
        .fll_lock_i      (fll_lock_i),
        .lock_o          (lock_o),
        .lock_lost_o     (lock_lost_o),
        .lock_lost_clr_i (lock_lost_clr_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Slave: ack rises once req has been high ack_dly cycles, drops one cycle after req.
    always @(posedge clk) begin
        if (fll_req_o) begin
            hi_cnt = hi_cnt + 1;
            if (hi_cnt >= ack_dly) fll_ack_i <= 1'b1;
        end else begin
            hi_cnt = 0;
            fll_ack_i <= 1'b0;
        end
        if (ack_force) fll_ack_i <= 1'b1;
    end

    // Request monitor: fields must match the issued command while req is high and one cycle after.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fll_req_o) begin
                req_len++;
                check_eq("req_fields", {fll_wrn_o, fll_add_o, fll_data_o}, exp_fields);
            end else if (req_prev) begin
                check_eq("fields_after_fall", {fll_wrn_o, fll_add_o, fll_data_o}, exp_fields);
            end
        end
        req_prev = fll_req_o;
    end

    // One command end to end; dly >= TO means the slave is too slow and a timeout is expected.
    task automatic do_cmd(input logic wrn, input logic [1:0] add, input logic [31:0] data,
                          input logic [31:0] rd, input int dly, input bit keep,
                          output int acc, output int waited);
        int n;
        int spur;
        int lat;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_wrn_i = wrn;
        cmd_add_i = add;
        cmd_data_i = data;
        fll_r_data_i = rd;
        ack_dly = dly;
        exp_fields = {wrn, add, data};
        #1;
        waited = 0;
        while (!cmd_ready_o && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        check_eq("accept_in_time", waited < 100, 1);
        acc = cyc;
        req_len = 0;
        @(negedge clk);
        if (!keep) cmd_valid_i = 1'b0;
        #1;
        n = 0;
        spur = 0;
        while (!rsp_valid_o && n < 200) begin
            if (cmd_valid_i && cmd_ready_o) spur++;
            @(negedge clk); #1;
            n++;
        end
        if (cmd_valid_i && cmd_ready_o) spur++;
        check_eq("rsp_seen", n < 200, 1);
        check_eq("busy_no_accept", spur, 0);
        lat = cyc - acc;
        if (dly < TO) begin
            check_eq("rsp_latency", lat, 4 + dly);
            check_eq("req_len", req_len, dly + 1);
            check_eq("rsp_rdata", rsp_rdata_o, wrn ? rd : 32'h0);
            check_eq("rsp_err", rsp_err_o, 0);
        end else begin
            check_eq("tmo_latency", lat, TO + 1);
            check_eq("tmo_req_len", req_len, TO);
            check_eq("tmo_rdata", rsp_rdata_o, 0);
            check_eq("tmo_err", rsp_err_o, 1);
        end
    endtask

    // One cycle of the lock model: lock_o is the input two cycles back, loss sticky with set priority.
    task automatic lock_cycle(input logic v, input logic c);
        @(negedge clk);
        check_eq("lock_o", lock_o, lin_h[cyc-2]);
        check_eq("lock_lost", lock_lost_o, exp_lost);
        if (!lin_h[cyc-2] && lin_h[cyc-3]) exp_lost = 1'b1;
        else if (c) exp_lost = 1'b0;
        fll_lock_i = v;
        lin_h[cyc] = v;
        lock_lost_clr_i = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, w, nrsp;
        logic v, c;
        for (int i = 0; i < 8192; i++) lin_h[i] = 1'b0;

        // Reset state, with a command already presented.
        cmd_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready", cmd_ready_o, 0);
        check_eq("rst_outs", {fll_req_o, fll_wrn_o, fll_add_o, fll_data_o},  0);
        check_eq("rst_rsp", {rsp_valid_o, rsp_rdata_o, rsp_err_o}, 0);
        check_eq("rst_lock", {lock_o, lock_lost_o}, 0);
        cmd_valid_i = 1'b0;
        rst_i = 1'b0;

        // Lock monitor: directed drops with a clear coinciding with the second drop, then random.
        for (int i = 0; i < 36; i++) begin
            v = (i < 6) || (i >= 12 && i < 20) || (i >= 28);
            c = (i == 22) || (i == 30);
            lock_cycle(v, c);
        end
        for (int i = 0; i < 40; i++) begin
            lock_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        lock_cycle(1'b1, 1'b0);
        lock_cycle(1'b1, 1'b0);

        // Write against the one-cycle-delay slave.
        do_cmd(1'b0, 2'd2, 32'h0000_1234, 32'hA5A5_5A5A, 1, 1'b0, a1, w);
        // Read with a ten-cycle ack delay, then the response data must hold.
        do_cmd(1'b1, 2'd1, 32'h0, 32'hDEAD_BEAF, 10, 1'b0, a1, w);
        @(negedge clk); #1;
        check_eq("rdata_hold", rsp_rdata_o, 32'hDEAD_BEAF);
        check_eq("valid_one_cycle", rsp_valid_o, 0);
        // Slave never acks.
        do_cmd(1'b0, 2'd3, $urandom, 32'h0, NEVER, 1'b0, a1, w);
        do_cmd(1'b1, 2'd0, $urandom, $urandom, 2, 1'b0, a1, w);

        // Timeout, then the ack rises late and sticks.
        do_cmd(1'b1, 2'd1, $urandom, $urandom, NEVER, 1'b0, a1, w);
        ack_force = 1'b1;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check_eq("stuck_ack_ready", cmd_ready_o, 0);
        end
        ack_force = 1'b0;
        do_cmd(1'b0, 2'd2, $urandom, $urandom, 1, 1'b0, a1, w);
        check_eq("ack_release_accept", w, 0);

        // Back-to-back with valid held.
        do_cmd(1'b0, 2'd1, $urandom, $urandom, 1, 1'b1, a1, w);
        do_cmd(1'b1, 2'd3, $urandom, $urandom, 1, 1'b0, a2, w);
        check_eq("b2b_gap", a2 - a1, 6);

        // Randomized commands.
        for (int i = 0; i < 20; i++) begin
            int d;
            d = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, 10));
            do_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                   d, 1'($urandom_range(0, 1)), a1, w);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;

        // Reset in the middle of REQ.
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        ack_dly = NEVER;
        cmd_valid_i = 1'b1;
        #1;
        w = 0;
        while (!cmd_ready_o && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk); #1;
        check_eq("req_before_rst", fll_req_o, 1);
        rst_i = 1'b1;
        @(negedge clk); #1;
        check_eq("req_after_rst", fll_req_o, 0);
        rst_i = 1'b0;
        nrsp = 0;
        for (int i = 0; i < 2 * TO; i++) begin
            @(negedge clk); #1;
            if (rsp_valid_o) nrsp++;
        end
        check_eq("no_rsp_after_rst", nrsp, 0);
        mon_en = 1'b1;
        do_cmd(1'b1, 2'd2, $urandom, 32'h1357_9BDF, 3, 1'b0, a1, w);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
